wb_bram_burst: RTL and testbench

WB_BRAM_BURST -- requirements
Module: wb_bram_burst

---
 rtl/wb_bram_burst.sv | 136 +++++++++++++
 tb/tb_wb_bram_burst.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave with registered ack and classic/burst cycles.
// Reads prefetch the next beat's word, so a burst moves one word per clock.
module wb_bram_burst #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [31:0]             adr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat_ms,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [DATA_WIDTH-1:0]   dat_sm,
  output logic                    ack,
  output logic                    err,
  output logic                    rty
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int L     = $clog2(NB);
  localparam int AW    = MEM_ADR_WIDTH;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CLASSIC = 2'd1;
  localparam logic [1:0] S_BURST   = 2'd2;

  logic [NB-1:0][7:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic                  ack_q, ack_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic [AW-1:0]      adr_w, rd_addr;
  logic [NB-1:0][7:0] rd_word;
  logic               burst_cti, beat_done, wr_en, load;
  logic               unused_adr;

  assign adr_w      = adr[AW+L-1:L];
  assign unused_adr = ^adr;
  assign burst_cti  = (cti == 3'b001) || (cti == 3'b010);
  assign beat_done  = cyc & stb & ack_q;
  assign wr_en      = beat_done & we;

  // Only the low bits selected by the wrap size change; linear wraps at memory end.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] c,
                                               input logic [1:0]    b,
                                               input logic [2:0]    t);
    logic [AW-1:0] m;
    logic [AW-1:0] inc;
    if (t != 3'b010) return c;
    case (b)
      2'b01:   m = AW'(3);
      2'b10:   m = AW'(7);
      2'b11:   m = AW'(15);
      default: m = '1;
    endcase
    inc = c + 1'b1;
    return (c & ~m) | (inc & m);
  endfunction

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;
    rd_addr = cnt_q;
    load    = 1'b0;
    if (!cyc) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (stb) begin
          ack_d   = 1'b1;
          cnt_d   = adr_w;
          rd_addr = adr_w;
          load    = 1'b1;
          state_d = burst_cti ? S_BURST : S_CLASSIC;
        end
        S_CLASSIC: state_d = S_IDLE;
        S_BURST: begin
          if (beat_done) begin
            if (burst_cti) begin
              ack_d   = 1'b1;
              cnt_d   = next_addr(cnt_q, bte, cti);
              rd_addr = cnt_d;
              load    = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else if (stb && !ack_q) begin
            ack_d = 1'b1;
            load  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Constant-address bursts may read the word being written on this same edge.
  always_comb begin
    rd_word = mem[rd_addr];
    for (int i = 0; i < NB; i++)
      if (wr_en && sel[i] && (rd_addr == cnt_q)) rd_word[i] = dat_ms[8*i +: 8];
    dat_d = load ? rd_word : dat_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < NB; i++)
        if (sel[i]) mem[cnt_q][i] <= dat_ms[8*i +: 8];
  end

  assign dat_sm = dat_q;
  assign ack    = ack_q;
  assign err    = 1'b0;
  assign rty    = 1'b0;
endmodule

// File: tb/tb_wb_bram_burst.sv
// Self-checking bench for wb_bram_burst: directed scenarios plus random
// bursts checked against a word-array model with arithmetic beat addressing.
module tb_wb_bram_burst;
  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_ms = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_sm;
  logic        ack, err, rty;

  always #5 clk = ~clk;

  wb_bram_burst #(.DATA_WIDTH(32), .MEM_ADR_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .dat_ms(dat_ms), .cti(cti), .bte(bte), .dat_sm(dat_sm), .ack(ack),
    .err(err), .rty(rty)
  );

  int passed = 0, total = 0;
  logic [31:0] mdl [DEPTH];
  logic        bw [DEPTH];
  logic [3:0]  bs [DEPTH];
  logic [31:0] bd [DEPTH];
  logic [31:0] last_rd;

  function automatic int beat_addr(input int start, input int k,
                                   input logic [2:0] mode, input logic [1:0] b);
    int blk;
    if (mode == 3'b001) return start;
    blk = (b == 2'b00) ? DEPTH : (2 << b);
    return (start - start % blk) + (start % blk + k) % blk;
  endfunction

  task automatic drive_beat(input int start, input int k, input int n,
                            input logic [2:0] mode, input logic [2:0] last,
                            input logic [1:0] b);
    cyc    = 1'b1;
    stb    = 1'b1;
    adr    = (k == 0) ? (($urandom << 13) | (32'(start) << 2)) : $urandom;
    we     = bw[k];
    sel    = bs[k];
    dat_ms = bd[k];
    cti    = (k == n - 1) ? last : mode;
    bte    = b;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  // Runs n beats; optional stb gap after beat gap_at, optional reset during beat rst_at.
  task automatic run_burst(input int start, input int n, input logic [2:0] mode,
                           input logic [2:0] last, input logic [1:0] b,
                           input int gap_at, input int gap_len, input int rst_at);
    int beat, cycles, gap_left, a, exp_cycles;
    bit gap_done, aborted;
    beat = 0; cycles = 0; gap_left = 0; gap_done = 0; aborted = 0;
    exp_cycles = n + 1 + ((gap_at >= 0 && gap_at < n) ? gap_len + 1 : 0);
    @(posedge clk); #1;
    drive_beat(start, 0, n, mode, last, b);
    while (beat < n) begin
      @(negedge clk);
      cycles++;
      if (ack && stb && beat == rst_at) begin
        rst = 1'b0;
        #1;
        total += 2;
        if (ack !== 1'b0) $display("FAIL rst_mid_ack: got %b want 0", ack); else passed++;
        if (dat_sm !== 32'h0) $display("FAIL rst_mid_dat: got %h want 0", dat_sm); else passed++;
        aborted = 1;
        break;
      end
      if (cycles > n + gap_len + 8) begin
        total++;
        $display("FAIL timeout: beat %0d of %0d after %0d cycles", beat, n, cycles);
        aborted = 1;
        break;
      end
      if (ack && stb) begin
        a = beat_addr(start, beat, mode, b);
        if (bw[beat]) begin
          for (int i = 0; i < 4; i++)
            if (bs[beat][i]) mdl[a][8*i +: 8] = bd[beat][8*i +: 8];
        end else begin
          total++;
          if (dat_sm !== mdl[a])
            $display("FAIL read_data: word %0d beat %0d got %h want %h", a, beat, dat_sm, mdl[a]);
          else passed++;
          last_rd = dat_sm;
        end
        beat++;
      end
      @(posedge clk); #1;
      if (beat >= n) break;
      if (beat == gap_at && !gap_done) begin gap_done = 1; gap_left = gap_len; end
      if (gap_left > 0) begin stb = 1'b0; gap_left--; end
      else drive_beat(start, beat, n, mode, last, b);
    end
    idle_bus();
    if (rst_at >= 0 && aborted) begin
      @(posedge clk); #1;
      rst = 1'b1;
    end else if (!aborted) begin
      total++;
      if (cycles !== exp_cycles)
        $display("FAIL burst_cycles: got %0d want %0d", cycles, exp_cycles);
      else passed++;
      @(negedge clk);
      total++;
      if (ack !== 1'b0) $display("FAIL ack_after_end: got %b want 0", ack); else passed++;
    end
  endtask

  task automatic classic(input int word, input logic w, input logic [3:0] s, input logic [31:0] d);
    bw[0] = w; bs[0] = s; bd[0] = d;
    run_burst(word, 1, 3'b000, 3'b000, 2'b00, -1, 0, -1);
  endtask

  task automatic expect_word(input int word, input logic [31:0] exp, input string name);
    classic(word, 1'b0, 4'h0, 32'h0);
    total++;
    if (last_rd !== exp) $display("FAIL %s: got %h want %h", name, last_rd, exp);
    else passed++;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    total += 4;
    if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack); else passed++;
    if (dat_sm !== 32'h0) $display("FAIL reset_dat: got %h want 0", dat_sm); else passed++;
    if (err !== 1'b0) $display("FAIL err_tied: got %b want 0", err); else passed++;
    if (rty !== 1'b0) $display("FAIL rty_tied: got %b want 0", rty); else passed++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic preload();
    for (int k = 0; k < DEPTH; k++) begin bw[k] = 1'b1; bs[k] = 4'hF; bd[k] = 32'(k); end
    run_burst(0, DEPTH, 3'b010, 3'b111, 2'b00, -1, 0, -1);
  endtask

  task automatic test_incr_read();
    for (int k = 0; k < 8; k++) bw[k] = 1'b0;
    run_burst(0, 8, 3'b010, 3'b111, 2'b00, -1, 0, -1);
    total++;
    if (last_rd !== 32'd7) $display("FAIL incr_last: got %h want 7", last_rd); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] v [4];
    v[0] = 32'hAAAA_0001; v[1] = 32'hBBBB_0002; v[2] = 32'hCCCC_0003; v[3] = 32'hDDDD_0004;
    for (int k = 0; k < 4; k++) begin bw[k] = 1'b1; bs[k] = 4'hF; bd[k] = v[k]; end
    run_burst(6, 4, 3'b010, 3'b111, 2'b01, -1, 0, -1);
    expect_word(6, v[0], "wrap_w6");
    expect_word(7, v[1], "wrap_w7");
    expect_word(4, v[2], "wrap_w4");
    expect_word(5, v[3], "wrap_w5");
    expect_word(8, 32'd8, "wrap_w8");
  endtask

  task automatic test_classic();
    classic(4, 1'b1, 4'hF, 32'hDEAD_BEEF);
    expect_word(4, 32'hDEAD_BEEF, "classic_rw");
    classic(8, 1'b1, 4'hF, 32'h1122_3344);
    classic(8, 1'b1, 4'h8, 32'hAA00_0000);
    expect_word(8, 32'hAA22_3344, "byte_lane");
  endtask

  task automatic test_stb_gap();
    for (int k = 0; k < 8; k++) bw[k] = 1'b0;
    run_burst(32, 8, 3'b010, 3'b111, 2'b00, 3, 2, -1);
  endtask

  task automatic test_rst_mid();
    for (int k = 0; k < 4; k++) begin bw[k] = 1'b1; bs[k] = 4'hF; bd[k] = 32'hC0DE_0000 + 32'(k); end
    run_burst(64, 4, 3'b010, 3'b111, 2'b00, -1, 0, 2);
    expect_word(64, 32'hC0DE_0000, "rst_w64");
    expect_word(65, 32'hC0DE_0001, "rst_w65");
    expect_word(66, 32'd66, "rst_w66");
    expect_word(67, 32'd67, "rst_w67");
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b000; adr = 32'd100 << 2;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (ack !== ((k % 2) == 0))
        $display("FAIL b2b_ack: cycle %0d got %b want %b", k, ack, (k % 2) == 0);
      else passed++;
      if (ack) begin
        total++;
        if (dat_sm !== mdl[100]) $display("FAIL b2b_data: got %h want %h", dat_sm, mdl[100]);
        else passed++;
      end
    end
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic test_random();
    int n, start, gap_at, gap_len;
    logic [2:0] mode;
    logic [1:0] b;
    for (int it = 0; it < 20; it++) begin
      mode  = ($urandom % 2) ? 3'b010 : 3'b001;
      b     = 2'($urandom % 4);
      n     = 2 + int'($urandom % 7);
      start = int'($urandom % DEPTH);
      gap_at  = ($urandom % 3 == 0) ? 1 + int'($urandom % (n - 1)) : -1;
      gap_len = 1 + int'($urandom % 3);
      for (int k = 0; k < n; k++) begin
        bw[k] = 1'($urandom % 2); bs[k] = 4'($urandom); bd[k] = $urandom;
      end
      run_burst(start, n, mode, 3'b111, b, gap_at, gap_len, -1);
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_incr_read();
    test_wrap();
    test_classic();
    test_stb_gap();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
